// File: rtl/fp8_mul_normalizer.sv
// Two-stage normalize/round/pack stage for the E4M3 multiply path; also drives the upstream multiplier register enable.
// Define FP8_MUL_SATURATE_EN to saturate overflow to the max finite magnitude instead of producing NaN.
module fp8_mul_normalizer #(
  parameter int LEN   = 4,
  parameter int EXP_W = 4,
  parameter int BIAS  = 7
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic [2*LEN-1:0]   s_axis_tdata_prod,
  input  logic [EXP_W-1:0]   s_axis_tdata_exp_a,
  input  logic [EXP_W-1:0]   s_axis_tdata_exp_b,
  input  logic               s_axis_tdata_sign,
  input  logic               s_axis_tuser,
  output logic               regenable,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic [7:0]         m_axis_tdata,
  output logic [2:0]         m_axis_tuser
);

  localparam int P  = 2 * LEN;
  localparam int M  = LEN - 1;
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] E_ONE  = EW'(1);
  localparam logic signed [EW-1:0] E_ZERO = EW'(0);
  localparam logic signed [EW-1:0] E_TOP  = EW'((1 << EXP_W) - 1);
`ifdef FP8_MUL_SATURATE_EN
  localparam logic [6:0] OVF_MAG = 7'h7E;
`else
  localparam logic [6:0] OVF_MAG = 7'h7F;
`endif

  logic                 adv1_s, adv2_s;
  logic                 v1_r, v2_r;
  logic                 sign1_r, nan1_r, zero1_r;
  logic [P-1:0]         prod1_r;
  logic signed [EW-1:0] e1_r;
  logic [EW-1:0]        e_sum_s;
  logic [7:0]           tdata_r;
  logic [2:0]           tuser_r;

  logic [M-1:0]         mant_s, mant_rnd_s, mant_fin_s;
  logic                 guard_s, sticky_s, carry_s;
  logic signed [EW-1:0] e_norm_s, e_fin_s;
  logic [7:0]           res_data_s;
  logic [2:0]           res_user_s;

  // Whole path stalls together: no skid buffer, so ready is combinational from downstream.
  assign adv2_s        = !v2_r || m_axis_tready;
  assign adv1_s        = !v1_r || adv2_s;
  assign s_axis_tready = adv1_s;
  assign regenable     = adv1_s;
  assign m_axis_tvalid = v2_r;
  assign m_axis_tdata  = tdata_r;
  assign m_axis_tuser  = tuser_r;

  assign e_sum_s = {2'b00, s_axis_tdata_exp_a} + {2'b00, s_axis_tdata_exp_b} - EW'(BIAS);

  // Normalize, round-to-nearest-even and classify the beat held in stage 1.
  always_comb begin
    mant_s     = '0;
    guard_s    = 1'b0;
    sticky_s   = 1'b0;
    e_norm_s   = e1_r;
    carry_s    = 1'b0;
    mant_rnd_s = '0;
    mant_fin_s = '0;
    e_fin_s    = e1_r;
    res_data_s = 8'h00;
    res_user_s = 3'b000;

    if (prod1_r[P-1]) begin
      mant_s   = prod1_r[P-2 -: M];
      guard_s  = prod1_r[P-LEN-1];
      sticky_s = |prod1_r[P-LEN-2:0];
      e_norm_s = e1_r + E_ONE;
    end else begin
      mant_s   = prod1_r[P-3 -: M];
      guard_s  = prod1_r[P-LEN-2];
      sticky_s = |prod1_r[P-LEN-3:0];
      e_norm_s = e1_r;
    end

    {carry_s, mant_rnd_s} = {1'b0, mant_s} + {{M{1'b0}}, guard_s & (sticky_s | mant_s[0])};

    if (carry_s) begin
      mant_fin_s = '0;
      e_fin_s    = e_norm_s + E_ONE;
    end else begin
      mant_fin_s = mant_rnd_s;
      e_fin_s    = e_norm_s;
    end

    if (nan1_r) begin
      res_data_s = {sign1_r, 7'h7F};
      res_user_s = 3'b100;
    end else if (zero1_r) begin
      res_data_s = {sign1_r, 7'h00};
      res_user_s = 3'b000;
    end else if (e_fin_s <= E_ZERO) begin
      res_data_s = {sign1_r, 7'h00};
      res_user_s = 3'b001;
    end else if ((e_fin_s > E_TOP) || ((e_fin_s == E_TOP) && (&mant_fin_s))) begin
      res_data_s = {sign1_r, OVF_MAG};
      res_user_s = 3'b010;
    end else begin
      res_data_s = {sign1_r, e_fin_s[EXP_W-1:0], mant_fin_s};
      res_user_s = 3'b000;
    end
  end

  // Stage 1 capture: operands, exponent sum and zero detect.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      v1_r    <= 1'b0;
      sign1_r <= 1'b0;
      nan1_r  <= 1'b0;
      zero1_r <= 1'b0;
      prod1_r <= '0;
      e1_r    <= '0;
    end else if (adv1_s) begin
      v1_r    <= s_axis_tvalid;
      sign1_r <= s_axis_tdata_sign;
      nan1_r  <= s_axis_tuser;
      zero1_r <= (s_axis_tdata_prod[P-1:P-2] == 2'b00);
      prod1_r <= s_axis_tdata_prod;
      e1_r    <= e_sum_s;
    end else begin
      v1_r    <= v1_r;
    end
  end

  // Stage 2 output register; holds while downstream stalls.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      v2_r    <= 1'b0;
      tdata_r <= 8'h00;
      tuser_r <= 3'b000;
    end else if (adv2_s) begin
      v2_r    <= v1_r;
      tdata_r <= res_data_s;
      tuser_r <= res_user_s;
    end else begin
      v2_r    <= v2_r;
    end
  end

endmodule

// File: doc/fp8_mul_normalizer.md
# fp8_mul_normalizer

Pipelined normalize/round/pack stage directly downstream of the 4-bit mantissa multiplier in the FP8 (E4M3) multiply path of the tensor core. It takes the raw 2·LEN-bit mantissa product plus the operand signs and biased exponents, normalizes, rounds to nearest-even, handles zero, underflow, overflow and NaN, and emits a packed 8-bit E4M3 result.

It is a 2-stage valid/ready pipeline. It also drives the upstream multiplier's register enable so the whole multiply path stalls together.

## Interface
Parameters:
- LEN, 4, mantissa width including hidden bit; product width is 2·LEN. Only the default is supported.
- EXP_W, 4, biased exponent width.
- BIAS, 7, exponent bias.

Ports:
- aclk  in  1  clock, all state on rising edge.
- areset  in  1  asynchronous, active-high reset.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat accepted when high with tvalid.
- s_axis_tdata_prod  in  2·LEN  mantissa product from the multiplier.
- s_axis_tdata_exp_a, s_axis_tdata_exp_b  in  EXP_W each  biased operand exponents.
- s_axis_tdata_sign  in  1  sign_a XOR sign_b, computed upstream.
- s_axis_tuser  in  1  NaN-operand flag from upstream unpack.
- regenable  out  1  enable for the upstream multiplier register; equals s_axis_tready.
- m_axis_tvalid  out  1  result valid.
- m_axis_tready  in  1  downstream accept.
- m_axis_tdata  out  8  E4M3 result: {sign, exp[3:0], mant[2:0]}.
- m_axis_tuser  out  3  {nan, overflow, underflow}.

## Operation
- Stage 1 (S1) registers:
  - sign, NaN flag and product.
  - Exponent sum e = exp_a + exp_b − BIAS, signed, EXP_W+2 bits.
  - Zero flag: prod[7:6]==00. Upstream forces the product to 0 for zero/subnormal operands, so any such product counts as zero.
- Stage 2 (S2) normalize:
  - If prod[7]=1: mant = prod[6:4], guard = prod[3], sticky = |prod[2:0], e = e+1.
  - Otherwise: mant = prod[5:3], guard = prod[2], sticky = |prod[1:0].
- S2 round to nearest-even:
  - Increment mant when guard & (sticky | mant[0]).
  - Mantissa carry-out: mant = 000, e = e+1.
- S2 classify, in priority order:
  1. NaN flag: tdata = {sign,7'h7F}, nan=1.
  2. Zero: tdata = {sign,7'h00}, no flags.
  3. e ≤ 0: tdata = {sign,7'h00}, underflow=1. No subnormal outputs.
  4. e > 15, or e==15 with mant==111 (the NaN encoding): overflow=1, tdata per Configuration.
  5. Otherwise tdata = {sign, e[3:0], mant}.
- Flags are exclusive.

## Timing
- Latency: 2 cycles from input acceptance to m_axis_tvalid with no backpressure. Throughput 1 beat/cycle.
- Valid bits v1 (S1) and v2 (S2).
  - adv2 = !v2 | m_axis_tready.
  - adv1 = !v1 | adv2.
  - s_axis_tready = regenable = adv1. This is a combinational path from m_axis_tready; no skid buffer.
- On adv1, S1 loads the input and v1 ← s_axis_tvalid. On adv2, S2 loads S1 and v2 ← v1.
- Stalled stages hold data bit-stable. m_axis_tdata/tuser must not change while m_axis_tvalid & !m_axis_tready.
- A simultaneous input accept and output accept in one cycle is legal and loses nothing.
- Reset values: v1=v2=0, m_axis_tvalid=0, m_axis_tdata=8'h00, m_axis_tuser=3'b000.
  - s_axis_tready and regenable read 1 during and after reset, since they are derived from v1/v2.
- Reset asserted mid-operation discards all in-flight beats immediately (asynchronous). No beat emerges afterward.

## Configuration
- FP8_MUL_SATURATE_EN defined: overflow result is {sign,7'h7E}, the max finite magnitude 448. overflow=1.
- Not defined: overflow result is {sign,7'h7F}, NaN. overflow=1, nan=0.

## Test plan
- 1.0×1.0: exp 7/7, prod 0x40, sign 0 → 0x38 two cycles later, tuser 000.
- 1.5×1.5 then 1.625×1.625, back to back:
  - prod 0x90, exp 7/7 → 0x41.
  - prod 0xA9, exp 7/7 → 0x43 (round up).
  - Results arrive on consecutive cycles.
- Exceptions:
  - Overflow: exp 15/15, prod 0x40 → 0x7E with FP8_MUL_SATURATE_EN, 0x7F without; tuser 010.
  - Underflow: exp 1/1, prod 0x40, sign 1 → 0x80, tuser 001.
  - NaN: s_axis_tuser=1 → 0x7F, tuser 100.
- Backpressure: m_axis_tready=0 for 6 cycles while offering 4 beats.
  - 2 beats accepted; then s_axis_tready = regenable = 0.
  - Output held stable.
  - After release, all 4 emerge in order, none lost or duplicated.
- Reset: assert areset with v1=v2=1 → m_axis_tvalid=0 and tdata=0 asynchronously. No stale beat after deassert.
